// File: rtl/queue_cnt_pkg.sv
// Package for the queue_cnt FIFO: width helpers and elaboration-time
// parameter checks shared by the top and its storage sub-module.
package queue_cnt_pkg;

   // Bits needed to hold an occupancy value in 0..n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Bits needed to address n storage slots (n >= 2, so never zero).
   function automatic int ptr_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Parameter "W": must be a positive width.
   function automatic bit check_param_pos(input int value);
      return value >= 1;
   endfunction

   // Parameter "N": must be at least lo.
   function automatic bit check_param_ge(input int value, input int lo);
      return value >= lo;
   endfunction

   // Parameter "AF": must lie in lo..hi inclusive.
   function automatic bit check_param_range(input int value, input int lo, input int hi);
      return (value >= lo) && (value <= hi);
   endfunction

endpackage

// File: rtl/queue_cnt_ram.sv
// queue_ram: W x N storage for queue_cnt. One write port (synchronous,
// qualified by clk_en and we) and one asynchronous read port, so the head
// item is visible in the same cycle its slot is addressed. Storage has no
// reset; validity is tracked entirely by the pointers and count in the top.
module queue_ram
   import queue_cnt_pkg::*;
#(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          clk_en,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [N];

   // Write the incoming item into its slot on an enabled clock edge.
   always_ff @(posedge clk) begin
      if (clk_en && we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/queue_cnt.sv
// queue_cnt: valid/ready FIFO of any depth N >= 2 with occupancy count,
// registered almost-full flag, synchronous flush and an optional
// empty-bypass path enabled by defining QUEUE_CNT_BYPASS_EN.
//
// Handshake semantics: a transfer happens on a rising clk edge with
// clk_en=1 when valid and ready are both high on that side
// (enq = i_valid && i_ready, deq = o_valid && o_ready). A producer holding
// valid must keep its data stable until ready is seen; ready may depend
// combinationally on the far side's ready (i_ready follows o_ready when
// full) but never on the same side's valid.
module queue_cnt
   import queue_cnt_pkg::*;
#(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int AF = N - 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clk_en,
   input  logic                  flush,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [W-1:0]          i,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [W-1:0]          o,
   output logic [cnt_w(N)-1:0]   count,
   output logic                  almost_full
);

   localparam int PW = ptr_w(N);
   localparam int CW = cnt_w(N);

   // Reject illegal configurations at elaboration.
   if (!check_param_pos(W)) begin : g_bad_w
      $error("queue_cnt: W must be >= 1");
   end
   if (!check_param_ge(N, 2)) begin : g_bad_n
      $error("queue_cnt: N must be >= 2");
   end
   if (!check_param_range(AF, 1, N)) begin : g_bad_af
      $error("queue_cnt: AF must be in 1..N");
   end

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          full_q;
   logic          o_valid_q;
   logic          almost_full_q;
   logic          enq;
   logic          deq;
   logic [W-1:0]  ram_rdata;

   // Explicit wrap at N-1 so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(N - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still accepts when the head leaves in the same cycle.
   assign i_ready = (!full_q || o_ready) && !flush;

`ifdef QUEUE_CNT_BYPASS_EN
   logic bypass_act;

   // When empty (and not flushing) the input is presented straight to the
   // output. An accepted pass-through is both an enq and a deq, so both
   // pointers advance together and the FIFO stays empty.
   assign bypass_act = !o_valid_q && !flush;
   assign o_valid    = bypass_act ? i_valid : o_valid_q;
   assign o          = bypass_act ? i : ram_rdata;
`else
   assign o_valid    = o_valid_q;
   assign o          = ram_rdata;
`endif

   assign enq = i_valid && i_ready;
   assign deq = o_valid && o_ready;

   assign count_next  = count_q + CW'(enq) - CW'(deq);
   assign count       = count_q;
   assign almost_full = almost_full_q;

   // Pointer, occupancy and flag update; flush clears everything and wins
   // over any handshake (a deq in that cycle is simply consumed).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count_q       <= '0;
         full_q        <= 1'b0;
         o_valid_q     <= 1'b0;
         almost_full_q <= 1'b0;
      end else if (clk_en) begin
         if (flush) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            o_valid_q     <= 1'b0;
            almost_full_q <= 1'b0;
         end else begin
            if (enq) begin
               wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
            count_q       <= count_next;
            full_q        <= (count_next == CW'(N));
            o_valid_q     <= (count_next != '0);
            almost_full_q <= (count_next >= CW'(AF));
         end
      end
   end

   queue_ram #(
      .W  (W),
      .N  (N),
      .AW (PW)
   ) u_ram (
      .clk    (clk),
      .clk_en (clk_en),
      .we     (enq && !flush),
      .waddr  (wr_ptr),
      .wdata  (i),
      .raddr  (rd_ptr),
      .rdata  (ram_rdata)
   );

endmodule

// File: tb/tb_queue_cnt.sv
// Bench for queue_cnt: W=8, N=5, AF=4 main instance plus an N=2 instance
// for the empty-bypass scenario. The reference is a plain item queue.
module tb_queue_cnt;

   localparam int W   = 8;
   localparam int N   = 5;
   localparam int AF  = 4;
   localparam int CW  = $clog2(N + 1);
   localparam int NB  = 2;
   localparam int CWB = $clog2(NB + 1);
`ifdef QUEUE_CNT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // clock / reset
   logic clk;
   logic rst_n;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic          clk_en;
   logic          flush;
   logic          i_valid;
   logic          i_ready;
   logic [W-1:0]  i;
   logic          o_valid;
   logic          o_ready;
   logic [W-1:0]  o;
   logic [CW-1:0] count;
   logic          almost_full;

   logic           b_flush;
   logic           b_i_valid;
   logic           b_i_ready;
   logic [W-1:0]   b_i;
   logic           b_o_valid;
   logic           b_o_ready;
   logic [W-1:0]   b_o;
   logic [CWB-1:0] b_count;
   logic           b_almost_full;

   queue_cnt #(.W(W), .N(N), .AF(AF)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
      .i_valid(i_valid), .i_ready(i_ready), .i(i),
      .o_valid(o_valid), .o_ready(o_ready), .o(o),
      .count(count), .almost_full(almost_full)
   );

   queue_cnt #(.W(W), .N(NB), .AF(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(b_flush),
      .i_valid(b_i_valid), .i_ready(b_i_ready), .i(b_i),
      .o_valid(b_o_valid), .o_ready(b_o_ready), .o(b_o),
      .count(b_count), .almost_full(b_almost_full)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model: the queue contents and the expected outputs this cycle
   logic [W-1:0]  mdl_q[$];
   logic          exp_ir;
   logic          exp_ov;
   logic [W-1:0]  exp_o;
   logic [CW-1:0] exp_cnt;
   logic          exp_af;

   task automatic model_outputs();
      exp_cnt = CW'(mdl_q.size());
      exp_af  = (mdl_q.size() >= AF);
      exp_ir  = ((mdl_q.size() < N) || o_ready) && !flush;
      exp_ov  = (mdl_q.size() != 0) || (BYP && i_valid && !flush);
      exp_o   = (mdl_q.size() != 0) ? mdl_q[0] : i;
   endtask

   task automatic model_update();
      logic m_enq;
      logic m_deq;
      m_enq = i_valid && exp_ir;
      m_deq = exp_ov && o_ready;
      if (clk_en) begin
         if (flush) begin
            mdl_q.delete();
         end else if (!(mdl_q.size() == 0 && m_deq)) begin
            if (m_deq) void'(mdl_q.pop_front());
            if (m_enq) mdl_q.push_back(i);
         end
      end
   endtask

   // driver: apply inputs at the falling edge, settle, compute expectations
   task automatic set_in(input logic v, input logic [W-1:0] d, input logic rdy,
                         input logic fl, input logic ce);
      @(negedge clk);
      i_valid = v;
      i       = d;
      o_ready = rdy;
      flush   = fl;
      clk_en  = ce;
      #1;
      model_outputs();
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b want 0", o_valid); end
      n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b want 0", almost_full); end
      n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %b want 1", i_ready); end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
         step();
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL pre_reset_count: got %0d want 4", count); end
      n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL pre_reset_af: got %b want 1", almost_full); end
      // assert reset between clock edges while a new item is being offered
      @(negedge clk);
      i_valid = 1'b1;
      i       = 8'h99;
      #2 rst_n = 1'b0;
      #1;
      mdl_q.delete();
      model_outputs();
      n_cmp++; if (o_valid !== exp_ov) begin n_err++; $display("FAIL async_ovalid: got %b want %b", o_valid, exp_ov); end
      n_cmp++; if (count !== '0) begin n_err++; $display("FAIL async_count: got %0d want 0", count); end
      n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL async_af: got %b want 0", almost_full); end
      @(negedge clk);
      rst_n   = 1'b1;
      i_valid = 1'b0;
      #1;
      n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_iready: got %b want 1", i_ready); end
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_ovalid: got %b want 0", o_valid); end
   endtask

   task automatic test_fill_wrap();
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, W'(8'h10 + k), 1'b0, 1'b0, 1'b1);
         n_cmp++; if (count !== CW'(k)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, count, k); end
         n_cmp++; if (almost_full !== (k >= AF)) begin n_err++; $display("FAIL fill_af[%0d]: got %b want %b", k, almost_full, (k >= AF)); end
         n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL fill_iready[%0d]: got %b want 1", k, i_ready); end
         step();
      end
      set_in(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (count !== CW'(5)) begin n_err++; $display("FAIL full_count: got %0d want 5", count); end
      n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_af: got %b want 1", almost_full); end
      n_cmp++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL full_iready: got %b want 0", i_ready); end
      step();
      for (int k = 0; k < 7; k++) begin
         set_in((k == 1) || (k == 2), W'(8'h14 + k), 1'b1, 1'b0, 1'b1);
         n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL drain_ovalid[%0d]: got %b want 1", k, o_valid); end
         n_cmp++; if (o !== W'(8'h10 + k)) begin n_err++; $display("FAIL drain_data[%0d]: got %h want %h", k, o, W'(8'h10 + k)); end
         n_cmp++; if (count !== exp_cnt) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", k, count, exp_cnt); end
         step();
      end
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (count !== '0) begin n_err++; $display("FAIL drained_count: got %0d want 0", count); end
      n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL drained_ovalid: got %b want 0", o_valid); end
   endtask

   task automatic test_full_simul();
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
         step();
      end
      set_in(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
      n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL simul_iready: got %b want 1", i_ready); end
      n_cmp++; if (o !== exp_o) begin n_err++; $display("FAIL simul_head: got %h want %h", o, exp_o); end
      step();
      for (int k = 0; k < 5; k++) begin
         set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
         if (k == 0) begin
            n_cmp++; if (count !== CW'(5)) begin n_err++; $display("FAIL simul_count: got %0d want 5", count); end
         end
         n_cmp++; if (o !== exp_o) begin n_err++; $display("FAIL simul_drain[%0d]: got %h want %h", k, o, exp_o); end
         if (k == 4) begin
            n_cmp++; if (o !== 8'hAA) begin n_err++; $display("FAIL simul_last: got %h want aa", o); end
         end
         step();
      end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1);
         step();
      end
      set_in(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
      n_cmp++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL flush_iready: got %b want 0", i_ready); end
      step();
      set_in(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (count !== '0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
      n_cmp++; if (o_valid !== exp_ov) begin n_err++; $display("FAIL flush_ovalid: got %b want %b", o_valid, exp_ov); end
      n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL flush_af: got %b want 0", almost_full); end
      step();
      set_in(1'b0, '0, 1'b1, 1'b0, 1'b1);
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL post_flush_ovalid: got %b want 1", o_valid); end
      n_cmp++; if (o !== 8'h55) begin n_err++; $display("FAIL post_flush_data: got %h want 55", o); end
      step();
   endtask

   task automatic test_clk_en();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, W'(8'h21 + k), 1'b0, 1'b0, 1'b1);
         step();
      end
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, W'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
         n_cmp++; if (count !== CW'(4)) begin n_err++; $display("FAIL ce_count[%0d]: got %0d want 4", k, count); end
         n_cmp++; if (o !== 8'h21) begin n_err++; $display("FAIL ce_data[%0d]: got %h want 21", k, o); end
         n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL ce_af[%0d]: got %b want 1", k, almost_full); end
         step();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         set_in(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
                ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1,
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 7) != 0));
         n_cmp++; if (i_ready !== exp_ir) begin n_err++; $display("FAIL rnd_iready[%0d]: got %b want %b", c, i_ready, exp_ir); end
         n_cmp++; if (o_valid !== exp_ov) begin n_err++; $display("FAIL rnd_ovalid[%0d]: got %b want %b", c, o_valid, exp_ov); end
         n_cmp++; if (count !== exp_cnt) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, exp_cnt); end
         n_cmp++; if (almost_full !== exp_af) begin n_err++; $display("FAIL rnd_af[%0d]: got %b want %b", c, almost_full, exp_af); end
         if (exp_ov) begin
            n_cmp++; if (o !== exp_o) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", c, o, exp_o); end
         end
         step();
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      clk_en    = 1'b1;
      b_i_valid = 1'b1;
      b_i       = 8'h3C;
      b_o_ready = 1'b1;
      #1;
`ifdef QUEUE_CNT_BYPASS_EN
      n_cmp++; if (b_o_valid !== 1'b1) begin n_err++; $display("FAIL byp_ovalid: got %b want 1", b_o_valid); end
      n_cmp++; if (b_o !== 8'h3C) begin n_err++; $display("FAIL byp_data: got %h want 3c", b_o); end
`else
      n_cmp++; if (b_o_valid !== 1'b0) begin n_err++; $display("FAIL nobyp_ovalid: got %b want 0", b_o_valid); end
`endif
      @(negedge clk);
      b_i_valid = 1'b0;
      #1;
`ifdef QUEUE_CNT_BYPASS_EN
      n_cmp++; if (b_count !== '0) begin n_err++; $display("FAIL byp_count: got %0d want 0", b_count); end
      n_cmp++; if (b_o_valid !== 1'b0) begin n_err++; $display("FAIL byp_after_ovalid: got %b want 0", b_o_valid); end
`else
      n_cmp++; if (b_o_valid !== 1'b1) begin n_err++; $display("FAIL nobyp_late_ovalid: got %b want 1", b_o_valid); end
      n_cmp++; if (b_o !== 8'h3C) begin n_err++; $display("FAIL nobyp_late_data: got %h want 3c", b_o); end
      n_cmp++; if (b_count !== CWB'(1)) begin n_err++; $display("FAIL nobyp_count: got %0d want 1", b_count); end
`endif
      @(negedge clk);
      #1;
      n_cmp++; if (b_count !== '0) begin n_err++; $display("FAIL byp_final_count: got %0d want 0", b_count); end
   endtask

   // watchdog so a stuck run still ends with a report
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      clk_en    = 1'b1;
      flush     = 1'b0;
      i_valid   = 1'b0;
      i         = '0;
      o_ready   = 1'b0;
      b_flush   = 1'b0;
      b_i_valid = 1'b0;
      b_i       = '0;
      b_o_ready = 1'b0;
      test_reset();
      test_fill_wrap();
      test_full_simul();
      test_flush();
      test_clk_en();
      test_random();
      test_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
